// File: rtl/fm_tx_pkg.sv
// Shared types and widths for the fm_tx retune path.
package fm_tx_pkg;

  localparam int GAIN_W = 16;
  localparam int FREQ_W = 32;

  // 80 MHz carrier at a 250 MHz NCO clock.
  localparam logic [FREQ_W-1:0] RESET_FREQ_DEF = 32'h51EB851F;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUTE   = 3'd1,
    SETTLE = 3'd2,
    RETUNE = 3'd3,
    UNMUTE = 3'd4
  } state_t;

endpackage

// File: rtl/fm_tune_seq_gain_ramp.sv
// Audio gain register with a tick prescaler and a saturating up/down stepper
// that walks toward a live target by at most GAIN_STEP per tick.
module gain_ramp
  import fm_tx_pkg::*;
#(
  parameter logic [GAIN_W-1:0] GAIN_STEP = 16'd64,
  parameter int unsigned       TICK_DIV  = 500
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [GAIN_W-1:0] load_val_i,
  input  logic              step_i,
  input  logic              restart_i,
  input  logic [GAIN_W-1:0] target_i,
  output logic [GAIN_W-1:0] gain_o,
  output logic              at_target_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [GAIN_W:0]   up_sum;
  logic              tick;

  always_comb begin
    tick   = step_i && (cnt_q == TICK_LAST);
    cnt_d  = cnt_q + CW'(1);
    if (!step_i || restart_i || tick) cnt_d = '0;

    // 17-bit sum so a target near full scale cannot wrap the ramp.
    up_sum = {1'b0, gain_q} + {1'b0, GAIN_STEP};
    gain_d = gain_q;
    if (load_i) begin
      gain_d = load_val_i;
    end else if (tick) begin
      if (gain_q < target_i) begin
        gain_d = (up_sum > {1'b0, target_i}) ? target_i : up_sum[GAIN_W-1:0];
      end else if (gain_q > target_i) begin
        gain_d = ((gain_q - target_i) > GAIN_STEP) ? (gain_q - GAIN_STEP) : target_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      gain_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      gain_q <= gain_d;
    end
  end

  assign gain_o      = gain_q;
  assign at_target_o = (gain_q == target_i);

endmodule

// File: rtl/fm_tune_seq.sv
// Retune sequencer: mutes audio and pilot around an NCO word change so the
// carrier hop produces no clicks; passes gains through (registered) when idle.
module fm_tune_seq
  import fm_tx_pkg::*;
#(
  parameter logic [FREQ_W-1:0] RESET_FREQ = RESET_FREQ_DEF,
  parameter logic [GAIN_W-1:0] GAIN_STEP  = 16'd64,
  parameter int unsigned       TICK_DIV   = 500,
  parameter int unsigned       SETTLE_CYC = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [FREQ_W-1:0] i_req_freq,
  input  logic              i_req_valid,
  input  logic [GAIN_W-1:0] i_audio_gain,
  input  logic [GAIN_W-1:0] i_pilot_gain,
  output logic [FREQ_W-1:0] o_rf_freq,
  output logic [GAIN_W-1:0] o_audio_gain,
  output logic [GAIN_W-1:0] o_pilot_gain,
  output logic              o_busy,
  output logic              o_done,
  output state_t            o_dbg_state
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic [FREQ_W-1:0] pend_freq_q, pend_freq_d;
  logic [FREQ_W-1:0] rf_freq_q, rf_freq_d;
  logic [GAIN_W-1:0] pilot_q, pilot_d;
  logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
  logic              busy_q, done_q, done_d;

  logic              ramp_load, ramp_step, ramp_restart, at_target;
  logic [GAIN_W-1:0] ramp_load_val, ramp_target, gain;

  // i_req_valid is a one-cycle strobe with no back-pressure: every strobe is
  // accepted in the cycle it is seen, and a newer word replaces any pending one.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_freq_d   = pend_freq_q;
    rf_freq_d     = rf_freq_q;
    pilot_d       = pilot_q;
    done_d        = 1'b0;
    settle_cnt_d  = '0;
    ramp_load     = 1'b0;
    ramp_load_val = '0;
    ramp_step     = 1'b0;
    ramp_target   = '0;

    if (i_req_valid && state_q != IDLE) begin
      pend_d      = 1'b1;
      pend_freq_d = i_req_freq;
    end

    case (state_q)
      IDLE: begin
        ramp_load     = 1'b1;
        ramp_load_val = i_audio_gain;
        pilot_d       = i_pilot_gain;
        if (i_req_valid) begin
          if (i_req_freq == rf_freq_q) begin
            done_d = 1'b1;
          end else begin
            pend_d      = 1'b1;
            pend_freq_d = i_req_freq;
            state_d     = MUTE;
          end
        end
      end
      MUTE: begin
        ramp_step = 1'b1;
        pilot_d   = i_pilot_gain;
        if (at_target) state_d = SETTLE;
      end
      SETTLE: begin
        ramp_load = 1'b1;
        pilot_d   = '0;
        if (settle_cnt_q == SETTLE_LAST) state_d = RETUNE;
        else settle_cnt_d = settle_cnt_q + SW'(1);
      end
      RETUNE: begin
        ramp_load = 1'b1;
        pilot_d   = '0;
        rf_freq_d = pend_freq_d;
        pend_d    = 1'b0;
        state_d   = UNMUTE;
      end
      UNMUTE: begin
        ramp_step   = 1'b1;
        ramp_target = i_audio_gain;
        pilot_d     = i_pilot_gain;
        if (at_target) begin
          done_d  = 1'b1;
          state_d = pend_d ? MUTE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ramp_restart = (state_d != state_q);
  end

  gain_ramp #(
    .GAIN_STEP (GAIN_STEP),
    .TICK_DIV  (TICK_DIV)
  ) u_ramp (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .load_i      (ramp_load),
    .load_val_i  (ramp_load_val),
    .step_i      (ramp_step),
    .restart_i   (ramp_restart),
    .target_i    (ramp_target),
    .gain_o      (gain),
    .at_target_o (at_target)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      pend_freq_q  <= '0;
      rf_freq_q    <= RESET_FREQ;
      pilot_q      <= '0;
      settle_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_freq_q  <= pend_freq_d;
      rf_freq_q    <= rf_freq_d;
      pilot_q      <= pilot_d;
      settle_cnt_q <= settle_cnt_d;
      busy_q       <= (state_d != IDLE);
      done_q       <= done_d;
    end
  end

  assign o_rf_freq    = rf_freq_q;
  assign o_audio_gain = gain;
  assign o_pilot_gain = pilot_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_dbg_state  = state_q;

endmodule
